// File: rtl/screen_switcher.sv
// Selects one of NUM_SCREENS VGA sources and switches between them on frame
// boundaries, optionally fading the picture out and back in around the cut.
module screen_switcher #(
    parameter int NUM_SCREENS = 5,
    parameter int RGB_W       = 12,
    parameter int FADE_EN     = 1,
    parameter int FADE_STEPS  = 8,
    localparam int SEL_W      = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SCREENS-1:0][10:0]      in_hcount,
    input  logic [NUM_SCREENS-1:0][10:0]      in_vcount,
    input  logic [NUM_SCREENS-1:0]            in_hsync,
    input  logic [NUM_SCREENS-1:0]            in_vsync,
    input  logic [NUM_SCREENS-1:0]            in_hblnk,
    input  logic [NUM_SCREENS-1:0]            in_vblnk,
    input  logic [NUM_SCREENS-1:0][RGB_W-1:0] in_rgb,
    input  logic [SEL_W-1:0]                  sel_idx,
    input  logic                              sel_valid,
    output logic [10:0]                       out_hcount,
    output logic [10:0]                       out_vcount,
    output logic                              out_hsync,
    output logic                              out_vsync,
    output logic                              out_hblnk,
    output logic                              out_vblnk,
    output logic [RGB_W-1:0]                  out_rgb,
    output logic [SEL_W-1:0]                  cur_idx,
    output logic                              busy,
    output logic [1:0]                        state_dbg
);

    localparam int LVL_W = $clog2(FADE_STEPS) + 1;
    localparam int SHIFT = $clog2(FADE_STEPS);
    localparam int CH_W  = RGB_W / 3;
    localparam logic [LVL_W-1:0] LVL_MAX = FADE_STEPS[LVL_W-1:0];
    localparam logic [SEL_W:0]   NUM_S   = NUM_SCREENS[SEL_W:0];

    // Handshake: a request is sel_valid high for one clk with sel_idx; there is
    // no ready. Out-of-range indices are dropped; in-range requests made while
    // busy land in a one-deep pending slot where the latest request wins.
    typedef enum logic [1:0] {IDLE, FADE_OUT, SWITCH, FADE_IN} state_t;
    localparam state_t START = (FADE_EN != 0) ? FADE_OUT : SWITCH;

    state_t           state;
    logic [LVL_W-1:0] level;
    logic [SEL_W-1:0] target;
    logic [SEL_W-1:0] pend_idx;
    logic             pend_valid;
    logic             vblnk_q;

    logic [10:0]      src_hcount;
    logic [10:0]      src_vcount;
    logic             src_hsync;
    logic             src_vsync;
    logic             src_hblnk;
    logic             src_vblnk;
    logic [RGB_W-1:0] src_rgb;
    logic             fb;
    logic             req_ok;
    logic             nxt_valid;
    logic [SEL_W-1:0] nxt_idx;
    logic             relaunch;

    assign src_hcount = in_hcount[cur_idx];
    assign src_vcount = in_vcount[cur_idx];
    assign src_hsync  = in_hsync[cur_idx];
    assign src_vsync  = in_vsync[cur_idx];
    assign src_hblnk  = in_hblnk[cur_idx];
    assign src_vblnk  = in_vblnk[cur_idx];
    assign src_rgb    = in_rgb[cur_idx];

    assign fb        = src_vblnk & ~vblnk_q;
    assign req_ok    = sel_valid && ({1'b0, sel_idx} < NUM_S);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // When a transition completes, a fresh request beats the pending one.
    always_comb begin
        nxt_valid = 1'b0;
        nxt_idx   = pend_idx;
        if (req_ok) begin
            nxt_valid = 1'b1;
            nxt_idx   = sel_idx;
        end else if (pend_valid) begin
            nxt_valid = 1'b1;
        end
    end

    // Completion always leaves cur_idx equal to target.
    assign relaunch = nxt_valid && (nxt_idx != target);

    function automatic logic [RGB_W-1:0] scale(input logic [RGB_W-1:0] rgb,
                                               input logic [LVL_W-1:0] lvl);
        logic [CH_W+LVL_W-1:0] prod;
        scale = '0;
        for (int c = 0; c < 3; c++) begin
            prod = {{LVL_W{1'b0}}, rgb[c*CH_W +: CH_W]} * {{CH_W{1'b0}}, lvl};
            scale[c*CH_W +: CH_W] = prod[SHIFT +: CH_W];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            level      <= LVL_MAX;
            cur_idx    <= '0;
            target     <= '0;
            pend_idx   <= '0;
            pend_valid <= 1'b0;
            vblnk_q    <= 1'b0;
            out_hcount <= '0;
            out_vcount <= '0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            vblnk_q    <= src_vblnk;
            out_hcount <= src_hcount;
            out_vcount <= src_vcount;
            out_hsync  <= src_hsync;
            out_vsync  <= src_vsync;
            out_hblnk  <= src_hblnk;
            out_vblnk  <= src_vblnk;
            out_rgb    <= (src_hblnk || src_vblnk) ? '0 : scale(src_rgb, level);

            if (state != IDLE && req_ok) begin
                pend_valid <= 1'b1;
                pend_idx   <= sel_idx;
            end

            case (state)
                IDLE: begin
                    if (req_ok && sel_idx != cur_idx) begin
                        target <= sel_idx;
                        state  <= START;
                    end
                end
                FADE_OUT: begin
                    if (fb) begin
                        level <= level - 1'b1;
                        if (level == {{(LVL_W-1){1'b0}}, 1'b1})
                            state <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (fb) begin
                        cur_idx <= target;
                        if (FADE_EN != 0) begin
                            state <= FADE_IN;
                        end else begin
                            pend_valid <= 1'b0;
                            if (relaunch) target <= nxt_idx;
                            state <= relaunch ? START : IDLE;
                        end
                    end
                end
                FADE_IN: begin
                    if (fb) begin
                        level <= level + 1'b1;
                        if (level == LVL_MAX - 1'b1) begin
                            pend_valid <= 1'b0;
                            if (relaunch) target <= nxt_idx;
                            state <= relaunch ? START : IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_switcher.sv
// Directed bench for screen_switcher: one fading and one hard-cut instance fed
// by the same shrunken video timing (16 x 10 totals, 12 x 8 active).
module tb_screen_switcher;

    localparam int N     = 5;
    localparam int RGB_W = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0][10:0]      in_hcount, in_vcount;
    logic [N-1:0]            in_hsync, in_vsync, in_hblnk, in_vblnk;
    logic [N-1:0][RGB_W-1:0] in_rgb;

    logic [2:0]       sel_idx_f, sel_idx_c;
    logic             sel_valid_f, sel_valid_c;
    logic [10:0]      out_hcount_f, out_vcount_f, out_hcount_c, out_vcount_c;
    logic             out_hsync_f, out_vsync_f, out_hblnk_f, out_vblnk_f;
    logic             out_hsync_c, out_vsync_c, out_hblnk_c, out_vblnk_c;
    logic [RGB_W-1:0] out_rgb_f, out_rgb_c;
    logic [2:0]       cur_idx_f, cur_idx_c;
    logic             busy_f, busy_c;
    logic [1:0]       state_dbg_f, state_dbg_c;

    screen_switcher #(.NUM_SCREENS(N), .RGB_W(RGB_W), .FADE_EN(1), .FADE_STEPS(8)) dut_f (
        .clk(clk), .rst(rst),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb), .sel_idx(sel_idx_f), .sel_valid(sel_valid_f),
        .out_hcount(out_hcount_f), .out_vcount(out_vcount_f),
        .out_hsync(out_hsync_f), .out_vsync(out_vsync_f),
        .out_hblnk(out_hblnk_f), .out_vblnk(out_vblnk_f),
        .out_rgb(out_rgb_f), .cur_idx(cur_idx_f), .busy(busy_f), .state_dbg(state_dbg_f)
    );

    screen_switcher #(.NUM_SCREENS(N), .RGB_W(RGB_W), .FADE_EN(0), .FADE_STEPS(8)) dut_c (
        .clk(clk), .rst(rst),
        .in_hcount(in_hcount), .in_vcount(in_vcount),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
        .in_rgb(in_rgb), .sel_idx(sel_idx_c), .sel_valid(sel_valid_c),
        .out_hcount(out_hcount_c), .out_vcount(out_vcount_c),
        .out_hsync(out_hsync_c), .out_vsync(out_vsync_c),
        .out_hblnk(out_hblnk_c), .out_vblnk(out_vblnk_c),
        .out_rgb(out_rgb_c), .cur_idx(cur_idx_c), .busy(busy_c), .state_dbg(state_dbg_c)
    );

    int checks = 0;
    int errors = 0;
    int gh, gv;
    logic [RGB_W-1:0] src_rgb [N];
    // Picture of an all-ones source (12'hFFF) at fade level 0..8.
    logic [RGB_W-1:0] lvl_rgb [9] = '{12'h000, 12'h111, 12'h333, 12'h555, 12'h777,
                                      12'h999, 12'hBBB, 12'hDDD, 12'hFFF};

    // Source s differs from the others only in vcount (+64*s) and colour.
    task automatic drive_sources();
        for (int s = 0; s < N; s++) begin
            in_hcount[s] = 11'(gh);
            in_vcount[s] = 11'(gv + s * 64);
            in_hsync[s]  = (gh == 13 || gh == 14);
            in_vsync[s]  = (gv == 9);
            in_hblnk[s]  = (gh >= 12);
            in_vblnk[s]  = (gv >= 8);
            in_rgb[s]    = src_rgb[s];
        end
    endtask

    always @(negedge clk) begin
        gh = gh + 1;
        if (gh == 16) begin
            gh = 0;
            gv = (gv == 9) ? 0 : gv + 1;
        end
        drive_sources();
    end

    // Advance to the edge at which the sources present (vv, hh), then settle.
    task automatic goto(input int vv, input int hh);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            if (gv == vv && gh == hh) found = 1'b1;
        end
        #7;
        if (!found) begin
            checks++; errors++;
            $display("FAIL goto_timeout got=not_found exp=v%0d_h%0d", vv, hh);
        end
    endtask

    task automatic pulse_f(input logic [2:0] idx);
        sel_idx_f = idx; sel_valid_f = 1'b1;
        @(posedge clk); #1;
        sel_valid_f = 1'b0;
    endtask

    task automatic pulse_c(input logic [2:0] idx);
        sel_idx_c = idx; sel_valid_c = 1'b1;
        @(posedge clk); #1;
        sel_valid_c = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #7;
        checks++;
        if ({cur_idx_f, busy_f, state_dbg_f} !== 6'b0) begin
            errors++; $display("FAIL reset_fsm_f got=%h exp=0", {cur_idx_f, busy_f, state_dbg_f});
        end
        checks++;
        if ({out_hcount_f, out_vcount_f, out_hsync_f, out_vsync_f, out_hblnk_f, out_vblnk_f, out_rgb_f} !== 38'b0) begin
            errors++; $display("FAIL reset_out_f got=%h exp=0", {out_hcount_f, out_vcount_f, out_rgb_f});
        end
        checks++;
        if ({cur_idx_c, busy_c, out_vcount_c, out_rgb_c} !== 27'b0) begin
            errors++; $display("FAIL reset_c got=%h exp=0", {cur_idx_c, busy_c, out_vcount_c, out_rgb_c});
        end
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [37:0] exp_v;
        src_rgb[0] = 12'h5A3;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            exp_v = {in_hcount[0], in_vcount[0], in_hsync[0], in_vsync[0], in_hblnk[0], in_vblnk[0],
                     (in_hblnk[0] | in_vblnk[0]) ? 12'h000 : in_rgb[0]};
            #7;
            checks++;
            if ({out_hcount_f, out_vcount_f, out_hsync_f, out_vsync_f, out_hblnk_f, out_vblnk_f, out_rgb_f} !== exp_v
                || busy_f !== 1'b0) begin
                errors++;
                $display("FAIL pass_f got=%h busy=%b exp=%h busy=0",
                         {out_hcount_f, out_vcount_f, out_hsync_f, out_vsync_f, out_hblnk_f, out_vblnk_f, out_rgb_f},
                         busy_f, exp_v);
            end
            checks++;
            if ({out_hcount_c, out_vcount_c, out_hsync_c, out_vsync_c, out_hblnk_c, out_vblnk_c, out_rgb_c} !== exp_v) begin
                errors++;
                $display("FAIL pass_c got=%h exp=%h",
                         {out_hcount_c, out_vcount_c, out_hsync_c, out_vsync_c, out_hblnk_c, out_vblnk_c, out_rgb_c}, exp_v);
            end
        end
    endtask

    task automatic test_ignored();
        logic [2:0] bad [3] = '{3'd7, 3'd5, 3'd0};
        for (int i = 0; i < 3; i++) begin
            goto(2, 3);
            sel_idx_c = bad[i]; sel_valid_c = 1'b1;
            pulse_f(bad[i]);
            sel_valid_c = 1'b0;
            repeat (3) @(posedge clk);
            #7;
            checks++;
            if ({busy_f, cur_idx_f, busy_c, cur_idx_c} !== 8'b0) begin
                errors++;
                $display("FAIL ignored_%0d got=%b exp=0", bad[i], {busy_f, cur_idx_f, busy_c, cur_idx_c});
            end
        end
    endtask

    task automatic test_hard_cut();
        src_rgb[3] = 12'hABC;
        goto(2, 3);
        pulse_c(3'd3);
        goto(7, 15);
        checks++;
        if (cur_idx_c !== 3'd0 || busy_c !== 1'b1) begin
            errors++; $display("FAIL cut_before got=%0d/%b exp=0/1", cur_idx_c, busy_c);
        end
        goto(8, 0);
        checks++;
        if (cur_idx_c !== 3'd3 || busy_c !== 1'b0) begin
            errors++; $display("FAIL cut_at_fb got=%0d/%b exp=3/0", cur_idx_c, busy_c);
        end
        goto(2, 3);
        checks++;
        if (out_rgb_c !== 12'hABC || out_vcount_c !== 11'd194 || cur_idx_c !== 3'd3) begin
            errors++; $display("FAIL cut_after got=%h/%0d exp=abc/194", out_rgb_c, out_vcount_c);
        end
        src_rgb[3] = 12'hFFF;
    endtask

    task automatic test_fade();
        int lvl;
        logic [2:0] cur;
        for (int s = 0; s < N; s++) src_rgb[s] = 12'hFFF;
        goto(2, 3);
        pulse_f(3'd2);
        for (int f = 1; f <= 17; f++) begin
            goto(2, 3);
            lvl = (f <= 8) ? 8 - f : (f == 9) ? 0 : f - 9;
            cur = (f < 9) ? 3'd0 : 3'd2;
            checks++;
            if (out_rgb_f !== lvl_rgb[lvl] || cur_idx_f !== cur || busy_f !== (f < 17)
                || out_vcount_f !== 11'(2 + 64 * cur)) begin
                errors++;
                $display("FAIL fade_frame%0d got=%h/%0d/%b exp=%h/%0d/%b",
                         f, out_rgb_f, cur_idx_f, busy_f, lvl_rgb[lvl], cur, f < 17);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lvl;
        logic [2:0] cur;
        goto(2, 3);
        pulse_f(3'd3);
        for (int i = 1; i <= 26; i++) begin
            goto(2, 3);
            if (i <= 16) begin
                lvl = (i <= 8) ? 8 - i : (i == 9) ? 0 : i - 9;
                cur = (i < 9) ? 3'd2 : 3'd3;
            end else begin
                lvl = (i - 17 <= 8) ? 8 - (i - 17) : 0;
                cur = (i < 26) ? 3'd3 : 3'd4;
            end
            checks++;
            if (out_rgb_f !== lvl_rgb[lvl] || cur_idx_f !== cur || busy_f !== 1'b1) begin
                errors++;
                $display("FAIL b2b_frame%0d got=%h/%0d/%b exp=%h/%0d/1",
                         i, out_rgb_f, cur_idx_f, busy_f, lvl_rgb[lvl], cur);
            end
            if (i == 1) pulse_f(3'd1);
            if (i == 2) pulse_f(3'd4);
        end
    endtask

    task automatic test_reset_mid();
        goto(2, 3);
        checks++;
        if (out_rgb_f !== 12'h111 || cur_idx_f !== 3'd4 || busy_f !== 1'b1) begin
            errors++; $display("FAIL mid_fade_in got=%h/%0d/%b exp=111/4/1", out_rgb_f, cur_idx_f, busy_f);
        end
        pulse_f(3'd1);
        #6;
        rst = 1'b1;
        @(posedge clk); #7;
        checks++;
        if ({cur_idx_f, busy_f, state_dbg_f, out_rgb_f, out_hcount_f, out_vcount_f, out_vblnk_f} !== 41'b0) begin
            errors++;
            $display("FAIL mid_reset got=%0d/%b/%0d/%h exp=0/0/0/000", cur_idx_f, busy_f, state_dbg_f, out_rgb_f);
        end
        rst = 1'b0;
        src_rgb[0] = 12'h5A3;
        for (int i = 0; i < 2; i++) begin
            goto(2, 3);
            checks++;
            if (out_rgb_f !== 12'h5A3 || cur_idx_f !== 3'd0 || busy_f !== 1'b0) begin
                errors++;
                $display("FAIL after_reset%0d got=%h/%0d/%b exp=5a3/0/0", i, out_rgb_f, cur_idx_f, busy_f);
            end
        end
    endtask

    initial begin
        gh = 0; gv = 0;
        for (int s = 0; s < N; s++) src_rgb[s] = 12'hFFF;
        drive_sources();
        rst = 1'b1;
        sel_idx_f = '0; sel_valid_f = 1'b0;
        sel_idx_c = '0; sel_valid_c = 1'b0;
        test_reset();
        test_passthrough();
        test_ignored();
        test_hard_cut();
        test_fade();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_switcher.md
SCREEN_SWITCHER -- requirements
Module: screen_switcher

Interface
REQ-001 Parameter NUM_SCREENS, default 5, number of VGA source channels; legal range 2..16.
REQ-002 Parameter RGB_W, default 12, rgb width; three equal channels of RGB_W/3 bits each.
REQ-003 Parameter FADE_EN, default 1; 1 = fade-out/fade-in transition, 0 = hard cut at frame boundary.
REQ-004 Parameter FADE_STEPS, default 8, power of two, number of frames per fade half.
REQ-005 Port clk  in  1  system pixel clock.
REQ-006 Port rst  in  1  synchronous, active-high reset.
REQ-007 Port in_hcount/in_vcount  in  NUM_SCREENS x 11  per-source pixel counters.
REQ-008 Port in_hsync/in_vsync/in_hblnk/in_vblnk  in  NUM_SCREENS x 1  per-source timing strobes.
REQ-009 Port in_rgb  in  NUM_SCREENS x RGB_W  per-source pixel colour.
REQ-010 Port sel_idx  in  clog2(NUM_SCREENS)  requested screen index.
REQ-011 Port sel_valid  in  1  one-cycle request strobe for sel_idx.
REQ-012 Port out_hcount/out_vcount  out  11  registered timing of the selected source.
REQ-013 Port out_hsync/out_vsync/out_hblnk/out_vblnk  out  1  registered strobes of the selected source.
REQ-014 Port out_rgb  out  RGB_W  registered, fade-scaled colour.
REQ-015 Port cur_idx  out  clog2(NUM_SCREENS)  screen currently driving the output.
REQ-016 Port busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 All out_* timing signals SHALL equal the cur_idx source inputs delayed by exactly 1 clk.
REQ-018 out_rgb SHALL be computed per colour channel as (ch * level) >> log2(FADE_STEPS), with level in 0..FADE_STEPS and no overflow; level = FADE_STEPS passes rgb unchanged.
REQ-019 out_rgb SHALL be forced to 0 whenever the selected source's hblnk or vblnk is high.
REQ-020 Frame boundary (FB) SHALL be the rising edge of the cur_idx source vblnk, detected with a registered previous value.
REQ-021 FSM states SHALL be IDLE, FADE_OUT, SWITCH and FADE_IN.
REQ-022 In IDLE, sel_valid with sel_idx < NUM_SCREENS and sel_idx != cur_idx SHALL latch target and enter FADE_OUT (FADE_EN=1) or SWITCH (FADE_EN=0) on the next clk.
REQ-023 Requests with sel_idx >= NUM_SCREENS, or with sel_idx == cur_idx while IDLE, SHALL be ignored.
REQ-024 In FADE_OUT, level SHALL decrement by 1 on each FB; when level reaches 0, the FSM SHALL enter SWITCH.
REQ-025 In SWITCH, cur_idx SHALL be loaded with the target on the next FB, and the FSM SHALL enter FADE_IN (FADE_EN=1) or IDLE (FADE_EN=0).
REQ-026 In FADE_IN, level SHALL increment by 1 on each FB; when level reaches FADE_STEPS, the FSM SHALL enter IDLE.
REQ-027 A valid sel_valid while busy SHALL be stored in a one-deep pending register; a later request overwrites it (latest wins).
REQ-028 On return to IDLE with pending set, the request SHALL be processed as a new request in the same clk and pending SHALL clear; if it equals cur_idx, it is dropped.
REQ-029 When sel_valid coincides with the transition into IDLE, the new sel_idx SHALL take priority over pending.
REQ-030 With FADE_EN=0, level SHALL remain FADE_STEPS at all times.

Reset
REQ-031 On rst: cur_idx=0, state=IDLE, level=FADE_STEPS, pending cleared, busy=0, all out_* = 0, vblnk history = 0.
REQ-032 rst asserted mid-transition SHALL abort it; the switcher restarts showing screen 0 at full level, with no pending request.

Verification
REQ-033 Reset, then all sources running 800x600 timing -> out_* equals source 0 delayed 1 clk, busy=0.
REQ-034 FADE_EN=1, FADE_STEPS=8, request idx 2 -> level steps 7..0 on 8 FBs, cur_idx=2 at the next FB, then level 1..8; busy for 17 frames; source rgb 12'hFFF at level 4 -> out_rgb 12'h777.
REQ-035 FADE_EN=0, request idx 3 -> cur_idx changes exactly at the next FB, busy for 1 frame, no rgb attenuation.
REQ-036 During a fade, requests for 1 then 4 -> after returning to IDLE, transition to 4 begins immediately; 1 is never shown.
REQ-037 Requests for idx 7 (NUM_SCREENS=5) and for the current idx -> ignored, busy stays 0.
REQ-038 rst pulse during FADE_IN -> next clk cur_idx=0, level=8, busy=0, out_* = 0.
